// File: rtl/mac_dot_sequencer_if.sv
// Operand stream, MAC pin bundle and result stream shared by the dot-product
// sequencer (slave) and its surrounding environment (master).
interface mac_dot_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PROD_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_a;
  logic [DATA_WIDTH-1:0] s_b;
  logic [DATA_WIDTH-1:0] s_c;
  logic [DATA_WIDTH-1:0] s_d;
  logic                  s_last;

  logic                  mac_ebl;
  logic [DATA_WIDTH-1:0] mac_a;
  logic [DATA_WIDTH-1:0] mac_b;
  logic [DATA_WIDTH-1:0] mac_c;
  logic [DATA_WIDTH-1:0] mac_d;
  logic [PROD_WIDTH-1:0] mac_out;
  logic                  mac_carry;

  logic                  m_valid;
  logic                  m_ready;
  logic [ACC_WIDTH-1:0]  m_data;
  logic [CNT_WIDTH-1:0]  m_count;
  logic                  m_overflow;

  modport slave (
    input  s_valid, s_a, s_b, s_c, s_d, s_last,
    output s_ready,
    output mac_ebl, mac_a, mac_b, mac_c, mac_d,
    input  mac_out, mac_carry,
    output m_valid, m_data, m_count, m_overflow,
    input  m_ready
  );

  modport master (
    output s_valid, s_a, s_b, s_c, s_d, s_last,
    input  s_ready,
    input  mac_ebl, mac_a, mac_b, mac_c, mac_d,
    output mac_out, mac_carry,
    input  m_valid, m_data, m_count, m_overflow,
    output m_ready
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Feeds operand quads into an external dual-product MAC, tracks in-flight beats
// with a tag pipeline and accumulates the MAC results into one result per vector.
module mac_dot_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PROD_WIDTH  = 16,
  parameter int unsigned MAC_LATENCY = 3,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input logic                clk,
  input logic                rst,
  mac_dot_sequencer_if.slave bus
);
  localparam int unsigned TERM_WIDTH = PROD_WIDTH + 1;
  localparam int unsigned SUM_WIDTH  = ACC_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_e;

  state_e state_q, state_d;
  logic   s_ready_c, mac_ebl_c;
  logic   accept, consume, consume_last;

  logic [DATA_WIDTH-1:0]  mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic [DATA_WIDTH-1:0]  mac_c_q, mac_c_d, mac_d_q, mac_d_d;
  logic [MAC_LATENCY-1:0] tag_valid_q, tag_valid_d, tag_last_q, tag_last_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, m_data_q, m_data_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc, m_count_q, m_count_d;
  logic                   ovf_q, ovf_d, ovf_next;
  logic                   m_valid_q, m_valid_d, m_overflow_q, m_overflow_d;
  logic [TERM_WIDTH-1:0]  term;
  logic [SUM_WIDTH-1:0]   sum;

  assign accept       = bus.s_valid && s_ready_c;
  assign consume      = mac_ebl_c && tag_valid_q[MAC_LATENCY-1];
  assign consume_last = consume && tag_last_q[MAC_LATENCY-1];

  // The extra sum bit is the accumulator carry-out; count saturation also flags overflow.
  assign term     = {bus.mac_carry, bus.mac_out};
  assign sum      = SUM_WIDTH'(acc_q) + SUM_WIDTH'(term);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign ovf_next = ovf_q | sum[ACC_WIDTH] | (cnt_q == '1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.s_last ? DRAIN : FEED;
      FEED:    if (accept && bus.s_last) state_d = DRAIN;
      DRAIN:   if (consume_last) state_d = HOLD;
      HOLD:    if (m_valid_q && bus.m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready_c = 1'b0;
    mac_ebl_c = 1'b1;
    case (state_q)
      IDLE, FEED: s_ready_c = 1'b1;
      HOLD:       mac_ebl_c = 1'b0;
      default:    ;
    endcase
  end

  // Datapath next-state: operand register, tag shift, accumulate and finalize.
  always_comb begin
    mac_a_d      = accept ? bus.s_a : '0;
    mac_b_d      = accept ? bus.s_b : '0;
    mac_c_d      = accept ? bus.s_c : '0;
    mac_d_d      = accept ? bus.s_d : '0;
    tag_valid_d  = tag_valid_q;
    tag_last_d   = tag_last_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_count_d    = m_count_q;
    m_overflow_d = m_overflow_q;

    if (mac_ebl_c) begin
      tag_valid_d = {tag_valid_q[MAC_LATENCY-2:0], accept};
      tag_last_d  = {tag_last_q[MAC_LATENCY-2:0], accept && bus.s_last};
    end

    if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;

    if (consume_last) begin
      m_valid_d    = 1'b1;
      m_data_d     = sum[ACC_WIDTH-1:0];
      m_count_d    = cnt_inc;
      m_overflow_d = ovf_next;
      acc_d        = '0;
      cnt_d        = '0;
      ovf_d        = 1'b0;
    end else if (consume) begin
      acc_d = sum[ACC_WIDTH-1:0];
      cnt_d = cnt_inc;
      ovf_d = ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      mac_c_q      <= '0;
      mac_d_q      <= '0;
      tag_valid_q  <= '0;
      tag_last_q   <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_count_q    <= '0;
      m_overflow_q <= 1'b0;
    end else begin
      mac_a_q      <= mac_a_d;
      mac_b_q      <= mac_b_d;
      mac_c_q      <= mac_c_d;
      mac_d_q      <= mac_d_d;
      tag_valid_q  <= tag_valid_d;
      tag_last_q   <= tag_last_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_count_q    <= m_count_d;
      m_overflow_q <= m_overflow_d;
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.mac_ebl    = mac_ebl_c;
  assign bus.mac_a      = mac_a_q;
  assign bus.mac_b      = mac_b_q;
  assign bus.mac_c      = mac_c_q;
  assign bus.mac_d      = mac_d_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_count    = m_count_q;
  assign bus.m_overflow = m_overflow_q;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural MAC, directed table, corner sequences
// and random vectors scored against an arithmetic dot-product model.
module tb_mac_dot_sequencer;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mac_dot_sequencer_if                   bus ();
  mac_dot_sequencer_if #(.ACC_WIDTH(20)) bus_w ();

  mac_dot_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));
  mac_dot_sequencer #(.ACC_WIDTH(20)) dut_w (.clk(clk), .rst(rst), .bus(bus_w.slave));

  function automatic logic [16:0] mac_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
    int unsigned ab, cd;
    ab = {24'd0, a} * {24'd0, b};
    cd = {24'd0, c} * {24'd0, d};
    return 17'(ab + cd);
  endfunction

  // The sequencer's operand register is the first of the three MAC stages.
  logic [16:0] mp1 = '0, mp2 = '0, wp1 = '0, wp2 = '0;
  always @(posedge clk) begin
    if (bus.mac_ebl) begin
      mp1 <= mac_f(bus.mac_a, bus.mac_b, bus.mac_c, bus.mac_d);
      mp2 <= mp1;
    end
    if (bus_w.mac_ebl) begin
      wp1 <= mac_f(bus_w.mac_a, bus_w.mac_b, bus_w.mac_c, bus_w.mac_d);
      wp2 <= wp1;
    end
  end
  assign bus.mac_out     = mp2[15:0];
  assign bus.mac_carry   = mp2[16];
  assign bus_w.mac_out   = wp2[15:0];
  assign bus_w.mac_carry = wp2[16];

  typedef struct { logic [7:0] a, b, c, d; } quad_t;
  typedef struct {
    logic [7:0]  a, b, c, d;
    int          nbeats, gap, hold;
    logic [31:0] exp_data;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  quad_t beats[$];
  vec_t  tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void model(output logic [31:0] d, output logic [7:0] c, output logic o);
    longint unsigned total;
    total = 0;
    foreach (beats[i])
      total += {56'd0, beats[i].a} * {56'd0, beats[i].b} + {56'd0, beats[i].c} * {56'd0, beats[i].d};
    d = total[31:0];
    o = (total[63:32] != 32'd0) || (beats.size() > 255);
    c = (beats.size() > 255) ? 8'hFF : 8'(beats.size());
  endfunction

  task automatic send_beats(input string tag, input int gap);
    int waited;
    for (int i = 0; i < beats.size(); i++) begin
      bus.s_valid = 1'b1;
      bus.s_a = beats[i].a; bus.s_b = beats[i].b; bus.s_c = beats[i].c; bus.s_d = beats[i].d;
      bus.s_last = (i == beats.size() - 1);
      waited = 0;
      while (!bus.s_ready && waited < 64) begin @(negedge clk); waited++; end
      check({tag, ".s_ready"}, 64'(bus.s_ready), 64'd1);
      @(negedge clk);
      check({tag, ".mac_ops"}, 64'({bus.mac_ebl, bus.mac_a, bus.mac_b, bus.mac_c, bus.mac_d}),
            64'({1'b1, beats[i].a, beats[i].b, beats[i].c, beats[i].d}));
      bus.s_valid = 1'b0; bus.s_last = 1'b0;
      bus.s_a = '0; bus.s_b = '0; bus.s_c = '0; bus.s_d = '0;
      if (i != beats.size() - 1)
        repeat (gap) begin
          @(negedge clk);
          check({tag, ".bubble"}, 64'({bus.mac_ebl, bus.mac_a, bus.mac_b, bus.mac_c, bus.mac_d}),
                64'({1'b1, 32'd0}));
        end
    end
  endtask

  task automatic collect(input string tag, input int hold, input logic [31:0] exp_data,
                         input logic [7:0] exp_cnt, input logic exp_ovf);
    int lat;
    logic [31:0] d0;
    logic [7:0]  c0;
    logic        o0;
    lat = 0;
    while (!bus.m_valid && lat < 64) begin @(negedge clk); lat++; end
    check({tag, ".latency"}, 64'(lat), 64'(LAT));
    check({tag, ".m_data"}, 64'(bus.m_data), 64'(exp_data));
    check({tag, ".m_count"}, 64'(bus.m_count), 64'(exp_cnt));
    check({tag, ".m_overflow"}, 64'(bus.m_overflow), 64'(exp_ovf));
    d0 = bus.m_data; c0 = bus.m_count; o0 = bus.m_overflow;
    repeat (hold) begin
      @(negedge clk);
      check({tag, ".hold"}, 64'({bus.m_valid, bus.s_ready, bus.m_data, bus.m_count, bus.m_overflow}),
            64'({1'b1, 1'b0, d0, c0, o0}));
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    check({tag, ".handshake"}, 64'({bus.m_valid, bus.s_ready}), 64'(2'b01));
  endtask

  initial begin
    logic [31:0] ed;
    logic [7:0]  ec;
    logic        eo;
    int          lat;

    tbl[0] = '{8'd3,   8'd4,   8'd5,   8'd6,   1, 0, 0, 32'd42,     8'd1, 1'b0};
    tbl[1] = '{8'd255, 8'd255, 8'd255, 8'd255, 4, 0, 0, 32'd520200, 8'd4, 1'b0};
    tbl[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 4, 2, 0, 32'd520200, 8'd4, 1'b0};
    tbl[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 4, 0, 5, 32'd520200, 8'd4, 1'b0};
    tbl[4] = '{8'd1,   8'd1,   8'd1,   8'd1,   1, 0, 0, 32'd2,      8'd1, 1'b0};

    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    bus.s_a = '0; bus.s_b = '0; bus.s_c = '0; bus.s_d = '0;
    bus_w.s_valid = 1'b0; bus_w.s_last = 1'b0; bus_w.m_ready = 1'b0;
    bus_w.s_a = '0; bus_w.s_b = '0; bus_w.s_c = '0; bus_w.s_d = '0;

    repeat (3) @(negedge clk);
    check("reset.outputs", 64'({bus.m_valid, bus.m_data, bus.m_count, bus.m_overflow}), 64'd0);
    check("reset.ready_ebl", 64'({bus.s_ready, bus.mac_ebl}), 64'(2'b11));
    check("reset.mac_ops", 64'({bus.mac_a, bus.mac_b, bus.mac_c, bus.mac_d}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table: single beat, back-to-back, bubbles, output backpressure, restart.
    for (int i = 0; i < 5; i++) begin
      beats.delete();
      repeat (tbl[i].nbeats) beats.push_back('{tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d});
      send_beats($sformatf("tbl%0d", i), tbl[i].gap);
      collect($sformatf("tbl%0d", i), tbl[i].hold, tbl[i].exp_data, tbl[i].exp_cnt, tbl[i].exp_ovf);
    end

    // Reset while draining discards the vector; the next one starts clean.
    beats.delete();
    beats.push_back('{8'd7, 8'd7, 8'd7, 8'd7});
    beats.push_back('{8'd9, 8'd9, 8'd9, 8'd9});
    send_beats("rstdrain", 0);
    check("rstdrain.in_drain", 64'(bus.s_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstdrain.after_rst", 64'({bus.m_valid, bus.s_ready}), 64'(2'b01));
    repeat (6) begin
      @(negedge clk);
      check("rstdrain.no_result", 64'(bus.m_valid), 64'd0);
    end
    beats.delete();
    beats.push_back('{8'd2, 8'd3, 8'd0, 8'd0});
    send_beats("rstnext", 0);
    collect("rstnext", 0, 32'd6, 8'd1, 1'b0);

    // 20-bit accumulator wraps after nine full-scale beats.
    bus_w.s_a = 8'd255; bus_w.s_b = 8'd255; bus_w.s_c = 8'd255; bus_w.s_d = 8'd255;
    check("wrap.s_ready", 64'(bus_w.s_ready), 64'd1);
    bus_w.s_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus_w.s_last = (i == 8);
      @(negedge clk);
    end
    bus_w.s_valid = 1'b0; bus_w.s_last = 1'b0;
    lat = 0;
    while (!bus_w.m_valid && lat < 64) begin @(negedge clk); lat++; end
    check("wrap.latency", 64'(lat), 64'(LAT));
    check("wrap.m_data", 64'(bus_w.m_data), 64'd121874);
    check("wrap.m_count", 64'(bus_w.m_count), 64'd9);
    check("wrap.m_overflow", 64'(bus_w.m_overflow), 64'd1);
    bus_w.m_ready = 1'b1;
    @(negedge clk);
    bus_w.m_ready = 1'b0;
    check("wrap.handshake", 64'({bus_w.m_valid, bus_w.s_ready}), 64'(2'b01));

    // Random vectors against the arithmetic model.
    for (int r = 0; r < 20; r++) begin
      beats.delete();
      repeat ($urandom_range(1, 6))
        beats.push_back('{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))});
      model(ed, ec, eo);
      send_beats($sformatf("rnd%0d", r), int'($urandom_range(0, 2)));
      collect($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), ed, ec, eo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
